xdble_sequencer: RTL and testbench

XDBLE_SEQUENCER -- requirements
Module: xdble_sequencer

---
 rtl/sike_hw_pkg.sv | 32 +++
 rtl/mem_copy_engine.sv | 83 ++++++++
 rtl/xdble_sequencer.sv | 173 +++++++++++++++++
 tb/tb_xdble_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sike_hw_pkg.sv
// Shared definitions for the SIKE hardware sequencers: FSM state encoding,
// copy channel count and a constant-evaluable clog2 helper.
package sike_hw_pkg;

    // xDBL sequencer states
    typedef enum logic [2:0] {
        XDBL_IDLE = 3'd0,
        XDBL_KICK = 3'd1,
        XDBL_WAIT = 3'd2,
        XDBL_COPY = 3'd3,
        XDBL_FIN  = 3'd4
    } xdbl_seq_state_e;

    // t2_0, t2_1, t3_0, t3_1 copied into X_0, X_1, Z_0, Z_1
    localparam int unsigned COPY_CHANNELS = 4;

    // Ceiling log2, usable in parameter expressions
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        r = 0;
        if (value > 1) begin
            v = value - 1;
            while (v > 0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_copy_engine.sv
// Streams addresses 0..WIDTH_REAL-1 to a set of synchronous-read source
// memories and replays each address one cycle later as a write to the
// destination memories, carrying the read data across unchanged.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   start_i       begin a copy pass (first read address issued next cycle)
//   rd_data_i     per-channel read data, valid one cycle after rd_addr_o
//   rd_en_o       shared read enable
//   rd_addr_o     shared read address
//   wr_en_o       shared write enable
//   wr_addr_o     shared write address
//   wr_data_c_o   per-channel write data (zero when not writing)
//   last_wr_c_o   high during the final write of the pass
module mem_copy_engine
    import sike_hw_pkg::*;
#(
    parameter int unsigned RADIX      = 16,
    parameter int unsigned WIDTH_REAL = 14,
    parameter int unsigned N_CH       = COPY_CHANNELS,
    parameter int unsigned DEPTH_LOG  = clog2(WIDTH_REAL)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start_i,
    input  logic [N_CH-1:0][RADIX-1:0]       rd_data_i,
    output logic                             rd_en_o,
    output logic [DEPTH_LOG-1:0]             rd_addr_o,
    output logic                             wr_en_o,
    output logic [DEPTH_LOG-1:0]             wr_addr_o,
    output logic [N_CH-1:0][RADIX-1:0]       wr_data_c_o,
    output logic                             last_wr_c_o
);

    localparam logic [DEPTH_LOG-1:0] LAST_ADDR = DEPTH_LOG'(WIDTH_REAL - 1);

    logic                 rd_en_q,   rd_en_d;
    logic [DEPTH_LOG-1:0] rd_addr_q, rd_addr_d;
    logic                 wr_en_q,   wr_en_d;
    logic [DEPTH_LOG-1:0] wr_addr_q, wr_addr_d;

    // Read address walker; stops at LAST_ADDR and parks at zero
    always_comb begin
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        if (start_i) begin
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
        end else if (rd_en_q) begin
            if (rd_addr_q == LAST_ADDR) begin
                rd_en_d   = 1'b0;
                rd_addr_d = '0;
            end else begin
                rd_addr_d = rd_addr_q + DEPTH_LOG'(1);
            end
        end
        // Write trails read by the one-cycle memory read latency
        wr_en_d   = rd_en_q;
        wr_addr_d = rd_en_q ? rd_addr_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    assign rd_en_o     = rd_en_q;
    assign rd_addr_o   = rd_addr_q;
    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    // Read data passes straight through; gated so idle/reset outputs read zero
    assign wr_data_c_o = wr_en_q ? rd_data_i : '0;
    assign last_wr_c_o = wr_en_q && (wr_addr_q == LAST_ADDR);

endmodule

// File: rtl/xdble_sequencer.sv
// Runs num_iter back-to-back xDBL point doublings: kicks the xDBL core,
// waits for its completion, then copies the t2/t3 result memories into the
// X/Z operand memories before the next doubling.
// Ports:
//   clk, rst            clock, async active-low reset (deassertion synchronised)
//   start, num_iter     one-cycle request and doubling count
//   busy, done          sequence in progress / one-cycle completion pulse
//   iter_cnt            doublings completed so far
//   core_start          start pulse to the xDBL controller
//   core_done           completion pulse from the xDBL controller
//   copy_active         sequencer owns the X/Z write and t2/t3 read ports
//   t_rd_en, t_rd_addr  shared read port of t2_0, t2_1, t3_0, t3_1
//   t*_dout             t memory read data
//   xz_wr_en, xz_wr_addr shared write port of X_0, X_1, Z_0, Z_1
//   X*/Z*_din           write data from t2_0, t2_1, t3_0, t3_1
module xdble_sequencer
    import sike_hw_pkg::*;
#(
    parameter int unsigned RADIX      = 16,
    parameter int unsigned WIDTH_REAL = 14,
    parameter int unsigned CNT_WIDTH  = 10,
    parameter int unsigned DEPTH_LOG  = clog2(WIDTH_REAL)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_iter,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] iter_cnt,
    output logic                 core_start,
    input  logic                 core_done,
    output logic                 copy_active,
    output logic                 t_rd_en,
    output logic [DEPTH_LOG-1:0] t_rd_addr,
    input  logic [RADIX-1:0]     t2_0_dout,
    input  logic [RADIX-1:0]     t2_1_dout,
    input  logic [RADIX-1:0]     t3_0_dout,
    input  logic [RADIX-1:0]     t3_1_dout,
    output logic                 xz_wr_en,
    output logic [DEPTH_LOG-1:0] xz_wr_addr,
    output logic [RADIX-1:0]     X_0_din,
    output logic [RADIX-1:0]     X_1_din,
    output logic [RADIX-1:0]     Z_0_din,
    output logic [RADIX-1:0]     Z_1_din
);

    localparam int unsigned NUM_CH = COPY_CHANNELS;

    // Reset: asserts asynchronously, releases two clock edges after rst rises
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    xdbl_seq_state_e      state_q, state_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic [CNT_WIDTH-1:0] iter_q, iter_d;
    logic [CNT_WIDTH-1:0] iter_inc;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 core_start_q, core_start_d;
    logic                 copy_active_q, copy_active_d;
    logic                 copy_go_c;
    logic                 last_wr_c;

    logic [NUM_CH-1:0][RADIX-1:0] rd_data;
    logic [NUM_CH-1:0][RADIX-1:0] wr_data_c;

    assign iter_inc = iter_q + CNT_WIDTH'(1);

    // Next-state logic; outputs decoded from the next state so they register
    // in step with state_q
    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        iter_d    = iter_q;
        copy_go_c = 1'b0;
        case (state_q)
            XDBL_IDLE: begin
                if (start) begin
                    iter_d = '0;
                    if (num_iter != '0) begin
                        num_d   = num_iter;
                        state_d = XDBL_KICK;
                    end else begin
                        state_d = XDBL_FIN;
                    end
                end
            end
            XDBL_KICK: state_d = XDBL_WAIT;
            XDBL_WAIT: begin
                if (core_done) begin
                    copy_go_c = 1'b1;
                    state_d   = XDBL_COPY;
                end
            end
            XDBL_COPY: begin
                if (last_wr_c) begin
                    iter_d  = iter_inc;
                    state_d = (iter_inc == num_q) ? XDBL_FIN : XDBL_KICK;
                end
            end
            XDBL_FIN:  state_d = XDBL_IDLE;
            default:   state_d = XDBL_IDLE;
        endcase
        busy_d        = (state_d == XDBL_KICK) || (state_d == XDBL_WAIT) ||
                        (state_d == XDBL_COPY);
        done_d        = (state_d == XDBL_FIN);
        core_start_d  = (state_d == XDBL_KICK);
        copy_active_d = (state_d == XDBL_COPY);
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q       <= XDBL_IDLE;
            num_q         <= '0;
            iter_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            core_start_q  <= 1'b0;
            copy_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_q         <= num_d;
            iter_q        <= iter_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            core_start_q  <= core_start_d;
            copy_active_q <= copy_active_d;
        end
    end

    // Channel order: 0=t2_0->X_0, 1=t2_1->X_1, 2=t3_0->Z_0, 3=t3_1->Z_1
    assign rd_data = {t3_1_dout, t3_0_dout, t2_1_dout, t2_0_dout};

    mem_copy_engine #(
        .RADIX      (RADIX),
        .WIDTH_REAL (WIDTH_REAL),
        .N_CH       (NUM_CH),
        .DEPTH_LOG  (DEPTH_LOG)
    ) u_copy (
        .clk         (clk),
        .rst_n       (rst_n_int),
        .start_i     (copy_go_c),
        .rd_data_i   (rd_data),
        .rd_en_o     (t_rd_en),
        .rd_addr_o   (t_rd_addr),
        .wr_en_o     (xz_wr_en),
        .wr_addr_o   (xz_wr_addr),
        .wr_data_c_o (wr_data_c),
        .last_wr_c_o (last_wr_c)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign iter_cnt    = iter_q;
    assign core_start  = core_start_q;
    assign copy_active = copy_active_q;
    assign X_0_din     = wr_data_c[0];
    assign X_1_din     = wr_data_c[1];
    assign Z_0_din     = wr_data_c[2];
    assign Z_1_din     = wr_data_c[3];

endmodule

// File: tb/tb_xdble_sequencer.sv
// Bench for xdble_sequencer: stub xDBL core, behavioural t/X/Z memories,
// table-driven runs, hand-written corner sequences and randomized runs.
module tb_xdble_sequencer;

    localparam int WR = 14;
    localparam int DL = 4;
    localparam int CW = 10;
    localparam int RX = 16;

    typedef logic [RX-1:0] img_t [WR];

    typedef struct {
        int n;
        int exp_starts;
        int exp_lat;
        int exp_writes;
        int exp_iter;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_iter;
    logic          busy, done, core_start, core_done, copy_active;
    logic [CW-1:0] iter_cnt;
    logic          t_rd_en, xz_wr_en;
    logic [DL-1:0] t_rd_addr, xz_wr_addr;
    logic [RX-1:0] t2_0_dout, t2_1_dout, t3_0_dout, t3_1_dout;
    logic [RX-1:0] X_0_din, X_1_din, Z_0_din, Z_1_din;

    logic stub_done, force_done;
    int   stub_dly;
    int   stub_cnt;
    int   cyc = 0;

    img_t t20, t21, t30, t31;
    img_t X0, X1, Z0, Z1;

    int n_cmp = 0;
    int n_err = 0;
    int n_cs, n_dn, n_wr;
    int pend;
    logic prev_rd_en;
    int   prev_rd_addr;

    xdble_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_iter    (num_iter),
        .busy        (busy),
        .done        (done),
        .iter_cnt    (iter_cnt),
        .core_start  (core_start),
        .core_done   (core_done),
        .copy_active (copy_active),
        .t_rd_en     (t_rd_en),
        .t_rd_addr   (t_rd_addr),
        .t2_0_dout   (t2_0_dout),
        .t2_1_dout   (t2_1_dout),
        .t3_0_dout   (t3_0_dout),
        .t3_1_dout   (t3_1_dout),
        .xz_wr_en    (xz_wr_en),
        .xz_wr_addr  (xz_wr_addr),
        .X_0_din     (X_0_din),
        .X_1_din     (X_1_din),
        .Z_0_din     (Z_0_din),
        .Z_1_din     (Z_1_din)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    assign core_done = stub_done | force_done;

    // Stub core: core_done rises stub_dly edges after the edge that samples
    // core_start; the "result" is a fresh random t image loaded at that moment.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            stub_cnt  <= 0;
            stub_done <= 1'b0;
        end else begin
            stub_done <= 1'b0;
            if (core_start) begin
                stub_cnt <= stub_dly;
            end else if (stub_cnt > 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1) begin
                    stub_done <= 1'b1;
                    for (int i = 0; i < WR; i++) begin
                        t20[i] <= RX'($urandom);
                        t21[i] <= RX'($urandom);
                        t30[i] <= RX'($urandom);
                        t31[i] <= RX'($urandom);
                    end
                end
            end
        end
    end

    // Synchronous-read t memories
    always @(posedge clk) begin
        if (t_rd_en && int'(t_rd_addr) < WR) begin
            t2_0_dout <= t20[int'(t_rd_addr)];
            t2_1_dout <= t21[int'(t_rd_addr)];
            t3_0_dout <= t30[int'(t_rd_addr)];
            t3_1_dout <= t31[int'(t_rd_addr)];
        end
    end

    // X/Z memories
    always @(posedge clk) begin
        if (xz_wr_en && int'(xz_wr_addr) < WR) begin
            X0[int'(xz_wr_addr)] <= X_0_din;
            X1[int'(xz_wr_addr)] <= X_1_din;
            Z0[int'(xz_wr_addr)] <= Z_0_din;
            Z1[int'(xz_wr_addr)] <= Z_1_din;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int n_diff(input img_t a, input img_t b);
        int c = 0;
        for (int i = 0; i < WR; i++) if (a[i] !== b[i]) c++;
        return c;
    endfunction

    // Protocol monitor: event counts, copy address stream, core_done gap
    always @(negedge clk) begin
        if (!rst) begin
            pend       = -1;
            prev_rd_en = 1'b0;
        end else begin
            if (core_done && busy && !copy_active && !core_start) pend = cyc;
            if ((core_start || done) && pend >= 0) begin
                chk("core_done_to_next_gap", cyc - pend, WR + 2);
                pend = -1;
            end
            if (core_start) n_cs++;
            if (done) n_dn++;
            if (t_rd_en) begin
                chk("rd_in_copy", int'(copy_active), 1);
                chk("rd_addr_seq", int'(t_rd_addr), prev_rd_en ? prev_rd_addr + 1 : 0);
                chk("rd_addr_range", int'(int'(t_rd_addr) < WR), 1);
            end
            if (xz_wr_en) begin
                n_wr++;
                chk("wr_in_copy", int'(copy_active), 1);
                chk("wr_follows_rd",
                    int'(prev_rd_en && int'(xz_wr_addr) == prev_rd_addr), 1);
            end
            prev_rd_en   = t_rd_en;
            prev_rd_addr = int'(t_rd_addr);
        end
    end

    task automatic pulse_start(input int n, output int s_cyc);
        @(negedge clk);
        start    = 1'b1;
        num_iter = CW'(n);
        s_cyc    = cyc;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int d_cyc, output bit ok);
        int k = 0;
        ok    = 1'b0;
        d_cyc = 0;
        while (!ok && k < budget) begin
            if (done === 1'b1) begin
                ok    = 1'b1;
                d_cyc = cyc;
            end else begin
                @(negedge clk);
                #1;
                k++;
            end
        end
    endtask

    task automatic chk_images(input string tag, input img_t e0, input img_t e1,
                              input img_t e2, input img_t e3);
        chk({tag, "_X0_words_wrong"}, n_diff(X0, e0), 0);
        chk({tag, "_X1_words_wrong"}, n_diff(X1, e1), 0);
        chk({tag, "_Z0_words_wrong"}, n_diff(Z0, e2), 0);
        chk({tag, "_Z1_words_wrong"}, n_diff(Z1, e3), 0);
    endtask

    task automatic run_and_check(input string tag, input int n, input int dly,
                                 input int exp_starts, input int exp_lat,
                                 input int exp_writes, input int exp_iter);
        int   s_cyc, d_cyc;
        bit   ok;
        img_t s0, s1, s2, s3;
        stub_dly = dly;
        s0 = X0; s1 = X1; s2 = Z0; s3 = Z1;
        n_cs = 0; n_dn = 0; n_wr = 0;
        pulse_start(n, s_cyc);
        wait_done(400, d_cyc, ok);
        chk({tag, "_done_seen"}, int'(ok), 1);
        chk({tag, "_latency"}, d_cyc - s_cyc, exp_lat);
        chk({tag, "_iter_cnt"}, int'(iter_cnt), exp_iter);
        chk({tag, "_core_starts"}, n_cs, exp_starts);
        chk({tag, "_writes"}, n_wr, exp_writes);
        if (n == 0) chk_images(tag, s0, s1, s2, s3);
        else        chk_images(tag, t20, t21, t30, t31);
        @(negedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, n_dn, 1);
        chk({tag, "_done_low"}, int'(done), 0);
        chk({tag, "_busy_low"}, int'(busy), 0);
        chk({tag, "_iter_cnt_hold"}, int'(iter_cnt), exp_iter);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [4];
        int   s_cyc, d_cyc, s2_cyc;
        bit   ok;
        int   k;

        tbl[0] = '{2, 2, 75, 28, 2};
        tbl[1] = '{0, 0, 1, 0, 0};
        tbl[2] = '{1, 1, 38, 14, 1};
        tbl[3] = '{3, 3, 112, 42, 3};

        rst        = 1'b0;
        start      = 1'b0;
        num_iter   = '0;
        force_done = 1'b0;
        stub_dly   = 20;
        n_cs = 0; n_dn = 0; n_wr = 0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_core_start", int'(core_start), 0);
        chk("rst_copy_active", int'(copy_active), 0);
        chk("rst_rd_en", int'(t_rd_en), 0);
        chk("rst_wr_en", int'(xz_wr_en), 0);
        chk("rst_iter_cnt", int'(iter_cnt), 0);
        chk("rst_din_zero", int'((X_0_din | X_1_din | Z_0_din | Z_1_din) == '0), 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;

        // Spurious core_done while idle
        force_done = 1'b1;
        @(negedge clk);
        #1;
        force_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("spurious_busy", int'(busy), 0);
            chk("spurious_core_start", int'(core_start), 0);
            chk("spurious_copy", int'(copy_active), 0);
            @(negedge clk);
            #1;
        end

        // Table-driven runs with the 20-cycle stub
        for (int i = 0; i < 4; i++) begin
            run_and_check($sformatf("tbl%0d_n%0d", i, tbl[i].n), tbl[i].n, 20,
                          tbl[i].exp_starts, tbl[i].exp_lat, tbl[i].exp_writes,
                          tbl[i].exp_iter);
        end

        // start during WAIT is ignored and num_iter changes have no effect
        stub_dly = 20;
        n_cs = 0; n_dn = 0;
        pulse_start(2, s_cyc);
        repeat (5) @(negedge clk);
        start    = 1'b1;
        num_iter = CW'(5);
        @(negedge clk);
        start    = 1'b0;
        num_iter = CW'(7);
        wait_done(400, d_cyc, ok);
        chk("wait_start_done_seen", int'(ok), 1);
        chk("wait_start_core_starts", n_cs, 2);
        chk("wait_start_iter_cnt", int'(iter_cnt), 2);
        chk("wait_start_latency", d_cyc - s_cyc, 75);

        // Reset mid-COPY at address 7 of the second doubling
        stub_dly = 20;
        pulse_start(3, s_cyc);
        k = 0;
        ok = 1'b0;
        while (!ok && k < 300) begin
            if (copy_active && t_rd_en && int'(t_rd_addr) == 7 && int'(iter_cnt) == 1)
                ok = 1'b1;
            else begin
                @(negedge clk);
                #1;
                k++;
            end
        end
        chk("midcopy_reached", int'(ok), 1);
        chk("midcopy_wr_en_before", int'(xz_wr_en), 1);
        rst = 1'b0;
        #1;
        chk("midcopy_rst_wr_en", int'(xz_wr_en), 0);
        chk("midcopy_rst_busy", int'(busy), 0);
        chk("midcopy_rst_copy", int'(copy_active), 0);
        chk("midcopy_rst_rd_en", int'(t_rd_en), 0);
        chk("midcopy_rst_iter_cnt", int'(iter_cnt), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        run_and_check("post_rst", 1, 20, 1, 38, 14, 1);

        // Back-to-back: n=1 then n=2 with start the cycle after done
        stub_dly = 20;
        n_cs = 0; n_dn = 0; n_wr = 0;
        pulse_start(1, s_cyc);
        wait_done(400, d_cyc, ok);
        chk("b2b_first_done", int'(ok), 1);
        pulse_start(2, s2_cyc);
        chk("b2b_start_gap", s2_cyc - d_cyc, 1);
        wait_done(400, d_cyc, ok);
        chk("b2b_second_done", int'(ok), 1);
        chk("b2b_second_latency", d_cyc - s2_cyc, 75);
        chk("b2b_core_starts", n_cs, 3);
        chk("b2b_done_pulses", n_dn, 2);
        chk("b2b_iter_cnt", int'(iter_cnt), 2);
        chk("b2b_writes", n_wr, 3 * WR);
        chk_images("b2b", t20, t21, t30, t31);
        @(negedge clk);
        #1;

        // Randomized counts and core latencies against the rule-based model:
        // each doubling = 1 KICK + (dly+1) WAIT + (WR+1) COPY, plus 1 to FIN
        for (int r = 0; r < 6; r++) begin
            int n, dly;
            n   = int'($urandom_range(1, 4));
            dly = int'($urandom_range(2, 30));
            run_and_check($sformatf("rnd%0d_n%0d_d%0d", r, n, dly), n, dly, n,
                          1 + n * (1 + (dly + 1) + (WR + 1)), n * WR, n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
